sliding_window_gen: RTL and testbench



---
 rtl/sliding_window_gen_if.sv | 14 +
 rtl/sliding_window_gen.sv | 98 +++++++++
 tb/tb_sliding_window_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sliding_window_gen_if.sv
// sliding_window_gen_if: pixel-in and window-out valid/ready handshakes
interface sliding_window_gen_if #(
  parameter int BIT_DEPTH = 8,
  parameter int KSIZE     = 3
);
  logic                             in_valid;
  logic                             in_ready;
  logic [BIT_DEPTH-1:0]             in_data;
  logic                             win_valid;
  logic                             win_ready;
  logic [KSIZE*KSIZE*BIT_DEPTH-1:0] win_data;
  modport master (output in_valid, in_data, win_ready, input in_ready, win_valid, win_data);
  modport slave  (input in_valid, in_data, win_ready, output in_ready, win_valid, win_data);
endinterface

// File: rtl/sliding_window_gen.sv
// sliding_window_gen: raster pixel stream to packed KxK windows using KSIZE-1 line memories
module sliding_window_gen #(
  parameter int BIT_DEPTH  = 8,
  parameter int KSIZE      = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  sliding_window_gen_if.slave s,
  output logic               frame_done,
  output logic               busy
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int WW = KSIZE * KSIZE * BIT_DEPTH;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(KSIZE - 2);
  localparam logic [RW-1:0] ROW_K    = RW'(KSIZE - 1);
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [WW-1:0]        win_q, win_d;
  logic [BIT_DEPTH-1:0] line_q [KSIZE-1][IMG_WIDTH];
  logic [BIT_DEPTH-1:0] col_v [KSIZE];
  logic                 active, accept, eol, produce, restart;
  assign active     = state_q == FILL || state_q == STREAM;
  assign s.in_ready = active && (!win_valid_q || s.win_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign eol        = col_q == COL_LAST;
  assign produce    = accept && row_q >= ROW_K && col_q >= COL_K;
  assign restart    = start && (state_q == IDLE || state_q == DONE);
  assign busy       = active;
  assign frame_done = frame_done_q;
  assign s.win_valid = win_valid_q;
  assign s.win_data  = win_q;
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    win_valid_d  = produce ? 1'b1 : win_valid_q && !s.win_ready;
    if (restart) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else if (accept) begin
      col_d = eol ? '0 : col_q + 1'b1;
      row_d = !eol ? row_q : (row_q == ROW_LAST ? '0 : row_q + 1'b1);
      if (eol && state_q == FILL && row_q == ROW_FILL) state_d = STREAM;
      if (eol && state_q == STREAM && row_q == ROW_LAST) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
      end
    end
  end
  // new rightmost window column: stored rows oldest first, incoming pixel last
  always_comb begin
    col_v[KSIZE-1] = s.in_data;
    for (int r = 0; r < KSIZE - 1; r++) col_v[r] = line_q[KSIZE-2-r][col_q];
    win_d = win_q;
    if (accept)
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++)
          win_d[(r*KSIZE+c)*BIT_DEPTH +: BIT_DEPTH] = win_q[(r*KSIZE+c+1)*BIT_DEPTH +: BIT_DEPTH];
        win_d[(r*KSIZE+KSIZE-1)*BIT_DEPTH +: BIT_DEPTH] = col_v[r];
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = KSIZE - 2; k > 0; k--) line_q[k][col_q] <= line_q[k-1][col_q];
      line_q[0][col_q] <= s.in_data;
    end
  end
endmodule

// File: tb/tb_sliding_window_gen.sv
// tb_sliding_window_gen: scoreboard bench for 3x3 over 4x4 and 2x2 over 5x3 frames
module tb_sliding_window_gen;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic fd, busy, fd2, busy2;
  int checks = 0, passes = 0, fd_cnt = 0, fd2_cnt = 0, wr_mode = 0;
  logic [71:0] sb3[$];
  logic [31:0] sb2[$];
  logic [71:0] exp3 [4] = '{72'h0a0908060504020100, 72'h0b0a09070605030201,
                            72'h0e0d0c0a0908060504, 72'h0f0e0d0b0a09070605};
  logic [31:0] exp2 [8] = '{32'h06050100, 32'h07060201, 32'h08070302, 32'h09080403,
                            32'h0b0a0605, 32'h0c0b0706, 32'h0d0c0807, 32'h0e0d0908};
  always #5 clk = ~clk;
  sliding_window_gen_if #(.BIT_DEPTH(8), .KSIZE(3)) a();
  sliding_window_gen_if #(.BIT_DEPTH(8), .KSIZE(2)) b();
  sliding_window_gen #(.BIT_DEPTH(8), .KSIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(a.slave), .frame_done(fd), .busy(busy));
  sliding_window_gen #(.BIT_DEPTH(8), .KSIZE(2), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .s(b.slave), .frame_done(fd2), .busy(busy2));
  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  always @(negedge clk) begin
    if (fd) fd_cnt++;
    if (fd2) fd2_cnt++;
    if (a.win_valid && a.win_ready) begin
      chk("dut3 expected window available", 72'(sb3.size() != 0), 1);
      if (sb3.size() != 0) chk("dut3 window", a.win_data, sb3.pop_front());
    end
    if (b.win_valid && b.win_ready) begin
      chk("dut2 expected window available", 72'(sb2.size() != 0), 1);
      if (sb2.size() != 0) chk("dut2 window", 72'(b.win_data), 72'(sb2.pop_front()));
    end
  end
  always @(posedge clk) begin
    #1;
    a.win_ready = wr_mode == 1 ? 1'($urandom_range(0, 1)) : wr_mode == 0;
  end
  task automatic push3(input int p, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    a.in_valid = 1;
    a.in_data  = 8'(p);
    do begin @(negedge clk); t++; end while (!a.in_ready && t < 200);
    if (!a.in_ready) chk("dut3 in_ready timeout", 72'(a.in_ready), 1);
    @(posedge clk); #1;
    a.in_valid = 0;
  endtask
  task automatic push2(input int p);
    int t = 0;
    b.in_valid = 1;
    b.in_data  = 8'(p);
    do begin @(negedge clk); t++; end while (!b.in_ready && t < 200);
    if (!b.in_ready) chk("dut2 in_ready timeout", 72'(b.in_ready), 1);
    @(posedge clk); #1;
    b.in_valid = 0;
  endtask
  task automatic start3();
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
  endtask
  task automatic frame3(input bit gaps, input bit lat, input bit ms, input bit stall);
    int f0 = fd_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i >= 10 && i % 4 >= 2) sb3.push_back(exp3[(i/4-2)*2 + i%4 - 2]);
      if (ms && i == 6) start = 1;
      if (stall && i == 10) begin wr_mode = 2; a.win_ready = 0; end
      push3(i, gaps);
      start = 0;
      if (lat && i == 10) chk("win_valid one cycle after px10", 72'(a.win_valid), 1);
      if (stall && i == 10) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall in_ready", 72'(a.in_ready), 0);
          chk("stall win_data", a.win_data, exp3[0]);
        end
        @(posedge clk); #1;
        wr_mode = 0;
        a.win_ready = 1;
      end
    end
    for (int t = 0; t < 200 && sb3.size() != 0; t++) @(negedge clk);
    chk("dut3 all windows seen", 72'(sb3.size()), 0);
    repeat (3) @(negedge clk);
    chk("frame_done pulse count", 72'(fd_cnt - f0), 1);
    chk("busy in DONE", 72'(busy), 0);
    chk("in_ready in DONE", 72'(a.in_ready), 0);
  endtask
  initial begin
    a.in_valid = 0; a.in_data = 0; a.win_ready = 1;
    b.in_valid = 0; b.in_data = 0; b.win_ready = 1;
    #1;
    chk("reset win_data", a.win_data, 0);
    chk("reset ctrl {in_ready,win_valid,frame_done,busy}", 72'({a.in_ready, a.win_valid, fd, busy}), 0);
    #13 rst_n = 1;
    start3();
    chk("busy in FILL", 72'(busy), 1);
    frame3(0, 1, 0, 0);
    start3();
    frame3(0, 0, 0, 1);
    wr_mode = 1;
    start3();
    frame3(1, 0, 0, 0);
    wr_mode = 0;
    start3();
    for (int i = 0; i < 10; i++) push3(i, 0);
    rst_n = 0;
    #1;
    chk("async reset win_data", a.win_data, 0);
    chk("async reset ctrl", 72'({a.in_ready, a.win_valid, fd, busy}), 0);
    #3 rst_n = 1;
    start3();
    frame3(0, 1, 0, 0);
    start3();
    frame3(0, 0, 1, 0);
    start3();
    frame3(0, 1, 0, 0);
    @(posedge clk); #1; start2 = 1;
    @(posedge clk); #1; start2 = 0;
    for (int i = 0; i < 15; i++) begin
      if (i / 5 >= 1 && i % 5 >= 1) sb2.push_back(exp2[(i/5-1)*4 + i%5 - 1]);
      push2(i);
    end
    for (int t = 0; t < 200 && sb2.size() != 0; t++) @(negedge clk);
    chk("dut2 all windows seen", 72'(sb2.size()), 0);
    repeat (3) @(negedge clk);
    chk("dut2 frame_done pulse count", 72'(fd2_cnt), 1);
    chk("dut2 busy in DONE", 72'(busy2), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
